// File: rtl/hazard_pkg.sv
// Shared types and encodings for the decode-stage hazard scoreboard.
package hazard_pkg;

    // Widest register index a stage entry can hold; narrower indices are zero-extended.
    localparam int ENTRY_RD_W      = 8;
    localparam int FWD_SEL_REGFILE = 0;

    typedef struct packed {
        logic                  valid;
        logic [ENTRY_RD_W-1:0] rd;
        logic                  rd_write;
        logic                  is_load;
    } stage_entry_t;

    function automatic int fwd_sel_width(input int num_stages);
        return $clog2(num_stages + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side request and hazard-response signals of the scoreboard.
interface hazard_scoreboard_if #(
    parameter int NUM_SRC    = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int SEL_W      = 2
);
    logic                          dec_valid;
    logic [NUM_SRC*ADDR_WIDTH-1:0] dec_rs;
    logic [NUM_SRC-1:0]            dec_rs_used;
    logic [ADDR_WIDTH-1:0]         dec_rd;
    logic                          dec_rd_write;
    logic                          dec_is_load;
    logic                          redirect;
    logic                          stall;
    logic                          flush_dec;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
    logic [31:0]                   stall_cycles;

    modport master (
        output dec_valid, dec_rs, dec_rs_used, dec_rd, dec_rd_write, dec_is_load, redirect,
        input  stall, flush_dec, fwd_sel, stall_cycles
    );

    modport slave (
        input  dec_valid, dec_rs, dec_rs_used, dec_rd, dec_rd_write, dec_is_load, redirect,
        output stall, flush_dec, fwd_sel, stall_cycles
    );
endinterface

// File: rtl/hazard_src_check.sv
// Finds the youngest in-flight producer of one source operand and decides
// whether its result can be forwarded this cycle.
module hazard_src_check
    import hazard_pkg::*;
#(
    parameter int ADDR_WIDTH       = 5,
    parameter int NUM_STAGES       = 3,
    parameter int FWD_ENABLE       = 1,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SEL_W            = 2
) (
    input  stage_entry_t [NUM_STAGES-1:0] i_stages,
    input  logic                          i_dec_valid,
    input  logic                          i_rs_used,
    input  logic [ADDR_WIDTH-1:0]         i_rs,
    output logic                          o_hazard,
    output logic                          o_ready,
    output logic [SEL_W-1:0]              o_sel
);
    logic             w_found;
    logic             w_load;
    logic [SEL_W-1:0] w_k;

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        w_found = 1'b0;
        w_load  = 1'b0;
        w_k     = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (i_stages[k].valid && i_stages[k].rd_write &&
                i_stages[k].rd == ENTRY_RD_W'(i_rs)) begin
                w_found = 1'b1;
                w_load  = i_stages[k].is_load;
                w_k     = SEL_W'(k + 1);
            end
        end
    end

    assign o_hazard = i_dec_valid & i_rs_used & (i_rs != '0) & w_found;
    assign o_ready  = (FWD_ENABLE != 0) && (!w_load || int'(w_k) >= LOAD_READY_STAGE);
    assign o_sel    = (o_hazard && o_ready) ? w_k : SEL_W'(FWD_SEL_REGFILE);

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks destinations in flight after
// decode and produces stall, decode flush and per-source forwarding selects.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS         = 32,
    parameter int ADDR_WIDTH       = $clog2(NUM_REGS),
    parameter int NUM_STAGES       = 3,
    parameter int NUM_SRC          = 2,
    parameter int FWD_ENABLE       = 1,
    parameter int LOAD_READY_STAGE = 2
) (
    input logic               clk,
    input logic               rst,
    hazard_scoreboard_if.slave bus
);
    localparam int SEL_W = fwd_sel_width(NUM_STAGES);

    stage_entry_t [NUM_STAGES-1:0] r_stages;
    logic [31:0]                   r_stall_cycles;
    stage_entry_t                  w_dec_entry;
    logic [NUM_SRC-1:0]            w_hazard;
    logic [NUM_SRC-1:0]            w_ready;
    logic [NUM_SRC*SEL_W-1:0]      w_src_sel;
    logic                          w_stall;
    logic                          w_accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            hazard_src_check #(
                .ADDR_WIDTH       (ADDR_WIDTH),
                .NUM_STAGES       (NUM_STAGES),
                .FWD_ENABLE       (FWD_ENABLE),
                .LOAD_READY_STAGE (LOAD_READY_STAGE),
                .SEL_W            (SEL_W)
            ) u_chk (
                .i_stages    (r_stages),
                .i_dec_valid (bus.dec_valid),
                .i_rs_used   (bus.dec_rs_used[gi]),
                .i_rs        (bus.dec_rs[gi*ADDR_WIDTH +: ADDR_WIDTH]),
                .o_hazard    (w_hazard[gi]),
                .o_ready     (w_ready[gi]),
                .o_sel       (w_src_sel[gi*SEL_W +: SEL_W])
            );
        end
    endgenerate

    // A redirect squashes decode, so a stall would only delay the refetch.
    assign w_stall  = (|(w_hazard & ~w_ready)) & ~bus.redirect;
    assign w_accept = bus.dec_valid & ~w_stall & ~bus.redirect;

    always_comb begin
        w_dec_entry          = '0;
        w_dec_entry.valid    = w_accept;
        w_dec_entry.rd       = ENTRY_RD_W'(bus.dec_rd);
        w_dec_entry.rd_write = bus.dec_rd_write;
        w_dec_entry.is_load  = bus.dec_is_load;
    end

    // Only the valid bits are reset; the payload of an invalid entry is ignored.
    always_ff @(posedge clk) begin
        for (int k = NUM_STAGES - 1; k >= 1; k--) begin
            r_stages[k] <= r_stages[k-1];
        end
        r_stages[0] <= w_dec_entry;
        if (rst) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_stages[k].valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall && r_stall_cycles != 32'hFFFF_FFFF) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.stall        = w_stall;
    assign bus.flush_dec    = bus.redirect;
    assign bus.fwd_sel      = w_stall ? '0 : w_src_sel;
    assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: a forwarding and a non-forwarding scoreboard share one
// stimulus stream and are checked against an issue-time reference model.
module tb_hazard_scoreboard;
    localparam int NR   = 32;
    localparam int AW   = 5;
    localparam int NS   = 3;
    localparam int NSRC = 2;
    localparam int LRS  = 2;
    localparam int SW   = $clog2(NS + 1);

    typedef struct {
        int unsigned    acc;
        logic [AW-1:0]  rd;
        bit             wr;
        bit             ld;
    } inst_t;

    typedef struct packed {
        logic                  stall;
        logic                  flush;
        logic [NSRC*SW-1:0]    sel;
        logic [31:0]           cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic                   dec_valid;
    logic [NSRC*AW-1:0]     dec_rs;
    logic [NSRC-1:0]        dec_rs_used;
    logic [AW-1:0]          dec_rd;
    logic                   dec_rd_write;
    logic                   dec_is_load;
    logic                   redirect;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NUM_SRC(NSRC), .ADDR_WIDTH(AW), .SEL_W(SW)) bus_f ();
    hazard_scoreboard_if #(.NUM_SRC(NSRC), .ADDR_WIDTH(AW), .SEL_W(SW)) bus_n ();

    assign bus_f.dec_valid    = dec_valid;
    assign bus_f.dec_rs       = dec_rs;
    assign bus_f.dec_rs_used  = dec_rs_used;
    assign bus_f.dec_rd       = dec_rd;
    assign bus_f.dec_rd_write = dec_rd_write;
    assign bus_f.dec_is_load  = dec_is_load;
    assign bus_f.redirect     = redirect;
    assign bus_n.dec_valid    = dec_valid;
    assign bus_n.dec_rs       = dec_rs;
    assign bus_n.dec_rs_used  = dec_rs_used;
    assign bus_n.dec_rd       = dec_rd;
    assign bus_n.dec_rd_write = dec_rd_write;
    assign bus_n.dec_is_load  = dec_is_load;
    assign bus_n.redirect     = redirect;

    hazard_scoreboard #(
        .NUM_REGS(NR), .ADDR_WIDTH(AW), .NUM_STAGES(NS), .NUM_SRC(NSRC),
        .FWD_ENABLE(1), .LOAD_READY_STAGE(LRS)
    ) dut_f (.clk(clk), .rst(rst), .bus(bus_f));

    hazard_scoreboard #(
        .NUM_REGS(NR), .ADDR_WIDTH(AW), .NUM_STAGES(NS), .NUM_SRC(NSRC),
        .FWD_ENABLE(0), .LOAD_READY_STAGE(LRS)
    ) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

    inst_t       fl_f[$];
    inst_t       fl_n[$];
    exp_t        sbq_f[$];
    exp_t        sbq_n[$];
    exp_t        exp_f;
    exp_t        exp_n;
    int unsigned cnt_f;
    int unsigned cnt_n;
    int unsigned n_edges;
    int          n_cmp;
    int          n_bad;

    // An instruction accepted at edge a sits in stage (n_edges - a + 1) until it leaves stage NS.
    function automatic exp_t predict(input inst_t fl[$], input bit fwd, input int unsigned cnt);
        exp_t e;
        bit   hz [NSRC];
        bit   rdy [NSRC];
        int   st [NSRC];
        bit   blocked;
        logic [AW-1:0] rs;
        blocked = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            hz[i]  = 1'b0;
            rdy[i] = 1'b0;
            st[i]  = 0;
            rs     = dec_rs[i*AW +: AW];
            if (dec_valid && dec_rs_used[i] && rs != '0) begin
                int best;
                bit bl;
                best = 0;
                bl   = 1'b0;
                foreach (fl[j]) begin
                    if (fl[j].wr && fl[j].rd == rs) begin
                        int s;
                        s = int'(n_edges - fl[j].acc) + 1;
                        if (best == 0 || s < best) begin
                            best = s;
                            bl   = fl[j].ld;
                        end
                    end
                end
                if (best != 0) begin
                    hz[i]  = 1'b1;
                    rdy[i] = fwd && (!bl || best >= LRS);
                    st[i]  = best;
                end
            end
            if (hz[i] && !rdy[i]) blocked = 1'b1;
        end
        e.stall = blocked && !redirect;
        e.flush = redirect;
        e.sel   = '0;
        if (!e.stall) begin
            for (int i = 0; i < NSRC; i++) begin
                if (hz[i] && rdy[i]) e.sel[i*SW +: SW] = SW'(st[i]);
            end
        end
        e.cnt = cnt;
        return e;
    endfunction

    task automatic advance_models();
        n_edges++;
        if (rst) begin
            fl_f.delete();
            fl_n.delete();
            cnt_f = 0;
            cnt_n = 0;
        end else begin
            if (exp_f.stall && cnt_f != 32'hFFFF_FFFF) cnt_f++;
            if (exp_n.stall && cnt_n != 32'hFFFF_FFFF) cnt_n++;
            if (dec_valid && !exp_f.stall && !redirect)
                fl_f.push_back('{n_edges, dec_rd, dec_rd_write, dec_is_load});
            if (dec_valid && !exp_n.stall && !redirect)
                fl_n.push_back('{n_edges, dec_rd, dec_rd_write, dec_is_load});
        end
        while (fl_f.size() > 0 && int'(n_edges - fl_f[0].acc) + 1 > NS) void'(fl_f.pop_front());
        while (fl_n.size() > 0 && int'(n_edges - fl_n[0].acc) + 1 > NS) void'(fl_n.pop_front());
    endtask

    task automatic step(input bit v, input int rs1, input int rs0, input bit [1:0] used,
                        input int rd, input bit wr, input bit ld, input bit redir, input bit r);
        dec_valid    = v;
        dec_rs       = {AW'(rs1), AW'(rs0)};
        dec_rs_used  = used;
        dec_rd       = AW'(rd);
        dec_rd_write = wr;
        dec_is_load  = ld;
        redirect     = redir;
        rst          = r;
        #1;
        exp_f = predict(fl_f, 1'b1, cnt_f);
        exp_n = predict(fl_n, 1'b0, cnt_n);
        sbq_f.push_back(exp_f);
        sbq_n.push_back(exp_n);
        @(posedge clk);
        advance_models();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 2'b00, 0, 0, 0, 0, 1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    exp_t me;
    initial begin
        forever begin
            @(negedge clk);
            if (sbq_f.size() > 0) begin
                me = sbq_f.pop_front();
                chk("fwd.stall",        32'(bus_f.stall),        32'(me.stall));
                chk("fwd.flush_dec",    32'(bus_f.flush_dec),    32'(me.flush));
                chk("fwd.fwd_sel",      32'(bus_f.fwd_sel),      32'(me.sel));
                chk("fwd.stall_cycles", bus_f.stall_cycles,      me.cnt);
            end
            if (sbq_n.size() > 0) begin
                me = sbq_n.pop_front();
                chk("nofwd.stall",        32'(bus_n.stall),      32'(me.stall));
                chk("nofwd.flush_dec",    32'(bus_n.flush_dec),  32'(me.flush));
                chk("nofwd.fwd_sel",      32'(bus_n.fwd_sel),    32'(me.sel));
                chk("nofwd.stall_cycles", bus_n.stall_cycles,    me.cnt);
            end
        end
    end

    initial begin
        n_cmp = 0; n_bad = 0; n_edges = 0; cnt_f = 0; cnt_n = 0;
        exp_f = '0; exp_n = '0;
        dec_valid = 0; dec_rs = '0; dec_rs_used = '0; dec_rd = '0;
        dec_rd_write = 0; dec_is_load = 0; redirect = 0; rst = 1;
        @(posedge clk);
        advance_models();
        #1;
        do_reset();
        idle(1);

        // ALU back-to-back: add x5 ; add x6, x5, x1
        do_reset();
        step(1, 0, 0, 2'b00, 5, 1, 0, 0, 0);
        step(1, 1, 5, 2'b11, 6, 1, 0, 0, 0);
        idle(4);

        // Load-use: lw x7 ; add x8, x7, x7 held in decode
        do_reset();
        step(1, 0, 0, 2'b00, 7, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 7, 7, 2'b11, 8, 1, 0, 0, 0);
        idle(4);

        // Dependent ALU pair held in decode until the non-forwarding core releases it
        do_reset();
        step(1, 0, 0, 2'b00, 5, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 5, 2'b01, 9, 1, 0, 0, 0);
        idle(4);

        // x0 writer and reader, then an immediate operand over a live match
        do_reset();
        step(1, 0, 0, 2'b00, 0, 1, 0, 0, 0);
        step(1, 0, 0, 2'b11, 3, 1, 0, 0, 0);
        step(1, 0, 0, 2'b00, 5, 1, 0, 0, 0);
        step(1, 5, 5, 2'b00, 4, 1, 0, 0, 0);
        idle(4);

        // Redirect in the same cycle as a load-use stall
        do_reset();
        step(1, 0, 0, 2'b00, 7, 1, 1, 0, 0);
        step(1, 7, 7, 2'b11, 8, 1, 0, 1, 0);
        step(1, 7, 7, 2'b11, 8, 1, 0, 0, 0);
        idle(4);

        // Reset while a load to x9 sits in stage 2
        do_reset();
        step(1, 0, 0, 2'b00, 9, 1, 1, 0, 0);
        idle(1);
        do_reset();
        step(1, 9, 9, 2'b11, 10, 1, 0, 0, 0);
        idle(4);

        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 7)),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 59) == 0);
        end
        idle(2);
        @(negedge clk);
        @(negedge clk);

        n_cmp++;
        if (sbq_f.size() + sbq_n.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected responses left unchecked, expected 0",
                     sbq_f.size() + sbq_n.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL take parameter NUM_REGS, default 32: architectural register count.
REQ-002 SHALL take parameter ADDR_WIDTH, default $clog2(NUM_REGS): register index width.
REQ-003 SHALL take parameter NUM_STAGES, default 3: tracked in-flight stages after decode; stage 1 = execute, NUM_STAGES = writeback.
REQ-004 SHALL take parameter NUM_SRC, default 2: source operands per instruction.
REQ-005 SHALL take parameter FWD_ENABLE, default 1: 1 = forward when ready, 0 = stall on every hazard.
REQ-006 SHALL take parameter LOAD_READY_STAGE, default 2: first stage holding load data.
REQ-007 SHALL have port clk  input  1: single clock, all state on posedge.
REQ-008 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-009 SHALL have port dec_valid  input  1: decode holds a valid instruction.
REQ-010 SHALL have port dec_rs  input  NUM_SRC*ADDR_WIDTH: source indices; source 0 in the LSBs.
REQ-011 SHALL have port dec_rs_used  input  NUM_SRC: source i is read, not an immediate.
REQ-012 SHALL have port dec_rd  input  ADDR_WIDTH: destination index.
REQ-013 SHALL have port dec_rd_write  input  1: instruction writes rd.
REQ-014 SHALL have port dec_is_load  input  1: instruction is a load.
REQ-015 SHALL have port redirect  input  1: taken branch/jump resolved in stage 1.
REQ-016 SHALL have port stall  output  1: hold fetch/decode; inject bubble into stage 1.
REQ-017 SHALL have port flush_dec  output  1: squash the decode instruction.
REQ-018 SHALL have port fwd_sel  output  NUM_SRC*$clog2(NUM_STAGES+1): 0 = register file, k = result held by stage k.
REQ-019 SHALL have port stall_cycles  output  32: saturating count of stall cycles.

Function
REQ-020 SHALL keep per stage k: valid, rd, rd_write, is_load; every entry shifts k -> k+1 each cycle; the stage NUM_STAGES entry retires.
REQ-021 SHALL, at each edge, load stage 1 with the decode instruction iff dec_valid & ~stall & ~redirect; otherwise load stage 1 with a bubble (valid=0).
REQ-022 SHALL treat source i as hazardous iff dec_valid, dec_rs_used[i], rs != 0, and some stage k has valid & rd_write & rd == rs.
REQ-023 SHALL, when several stages match, select the lowest k (youngest producer).
REQ-024 SHALL treat the selected producer as ready iff FWD_ENABLE=1 and (is_load=0 or k >= LOAD_READY_STAGE).
REQ-025 SHALL assert stall combinationally iff any source is hazardous and its producer is not ready, and redirect is low.
REQ-026 SHALL drive fwd_sel[i] = k for a ready hazardous source, else 0.
REQ-027 SHALL force fwd_sel to all zeros while stall is high.
REQ-028 SHALL drive flush_dec = redirect.
REQ-029 SHALL let redirect override stall in the same cycle: stall = 0, decode squashed, stage 1 receives a bubble.
REQ-030 SHALL leave the stage 1 producer that raised redirect untouched; it continues down the pipeline.
REQ-031 SHALL increment stall_cycles at each edge where stall = 1, saturating at 32'hFFFF_FFFF.
REQ-032 SHALL treat a match in stage NUM_STAGES as a hazard, because the register-file write lands at the end of that cycle.
REQ-033 SHALL produce no hazard for rd = 0 writers; x0 is never tracked as a dependency.

Reset
REQ-034 SHALL, while rst is high at an edge, clear all stage valid bits and clear stall_cycles.
REQ-035 SHALL, with all valids cleared, drive stall = 0, flush_dec = redirect, and fwd_sel = 0.
REQ-036 SHALL discard all in-flight entries on rst asserted mid-stall; there is no replay.

Structure
REQ-037 SHALL place the stage-entry struct (valid, rd, rd_write, is_load) and the fwd_sel encoding constants in a shared package, hazard_pkg.
REQ-038 SHALL implement per-source match/priority logic as one sub-module, hazard_src_check, instantiated NUM_SRC times.
REQ-039 SHALL contain no memory and no multi-cycle combinational paths; outputs depend only on stage state and decode/redirect inputs.

Verification
REQ-040 SHALL cover ALU back-to-back: add x5 then add x6,x5,x1 with FWD_ENABLE=1 -> stall=0, fwd_sel[0]=1 in the consumer's decode cycle.
REQ-041 SHALL cover load-use: lw x7 then add x8,x7,x7 -> exactly 1 stall cycle, then fwd_sel[0]=fwd_sel[1]=2, stall_cycles=1.
REQ-042 SHALL cover no forwarding: FWD_ENABLE=0, add x5 then use x5 -> stall for 3 cycles (NUM_STAGES), then fwd_sel=0, stall_cycles=3.
REQ-043 SHALL cover x0 and immediates: writer rd=0, reader rs=0; separately dec_rs_used=0 on a match -> stall=0, fwd_sel=0.
REQ-044 SHALL cover redirect during stall: load-use stall with redirect=1 in the same cycle -> stall=0, flush_dec=1, stage 1 bubble next cycle, counter unchanged.
REQ-045 SHALL cover reset mid-operation: rst high while stage 2 holds a load to x9 -> next cycle use of x9 gives stall=0, fwd_sel=0, stall_cycles=0.
